decoder_3to8_seq: RTL

DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

---
 rtl/decoder_3to8_seq_pkg.sv | 22 ++
 rtl/decoder_3to8_seq_onehot_dec3.sv | 11 +
 rtl/decoder_3to8_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/decoder_3to8_seq_pkg.sv
// Shared definitions for the sequenced 3-to-8 decoder: FSM state encoding,
// the 8-bit hold/gap counter type and the one-hot decode used both by the
// RTL and by companion benches as a golden model.
package decoder_3to8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef logic [7:0] cnt_t;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    // Binary code to one-hot: bit 'code' set, all others clear.
    function automatic logic [ONEHOT_W-1:0] onehot_dec(input logic [CODE_W-1:0] code);
        onehot_dec = 8'h01 << code;
    endfunction

endpackage

// File: rtl/decoder_3to8_seq_onehot_dec3.sv
// Purely combinational 3-to-8 one-hot decoder.
module onehot_dec3
    import decoder_3to8_seq_pkg::*;
(
    input  logic [2:0] code_i,
    output logic [7:0] onehot_o
);

    assign onehot_o = onehot_dec(code_i);

endmodule

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder. An accepted code is presented one-hot on d for
// HOLD_CYCLES cycles, followed by GAP_CYCLES forced all-zero cycles. A normal
// hold completion is flagged by a one-cycle done pulse; dropping en during a
// hold aborts it silently and returns straight to IDLE.
module decoder_3to8_seq
    import decoder_3to8_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,   // 1..255
    parameter int GAP_CYCLES  = 1    // 0..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic [7:0] d,
    output logic       busy,
    output logic       done
);

    // Counter reload values; the exit test happens at zero, so a load of N-1
    // yields exactly N cycles in the state.
    localparam cnt_t HOLD_LOAD = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t GAP_LOAD  = cnt_t'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    cnt_t       cnt_q,   cnt_d;
    logic [2:0] code_q,  code_d;
    logic [7:0] d_q,     d_d;
    logic       done_q,  done_d;
    logic [7:0] dec_out;
    logic       accept;

    // Handshake signals are decoded from state and en only.
    assign in_ready = (state_q == IDLE) && en;
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;

    // The latched code only changes on a transfer; decoding the next-state
    // code lets d show the new code in the first cycle after acceptance.
    assign code_d = accept ? in_code : code_q;

    onehot_dec3 u_dec (
        .code_i   (code_d),
        .onehot_o (dec_out)
    );

    // d is non-zero only while the next state is HOLD.
    assign d_d = (state_d == HOLD) ? dec_out : 8'h00;

    // Next-state logic for the IDLE/HOLD/GAP sequencer and its counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (!en) begin
                    // Abort: no done pulse, gap skipped.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                // en is deliberately ignored here; the gap always completes.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset overrides any transfer on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            d_q     <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    assign d    = d_q;
    assign done = done_q;

endmodule
